key_conditioner: RTL and testbench

Parametrised multi-channel front end for push-button and switch inputs. Each channel gets a configurable-depth synchroniser, a counter-based debouncer, and one-cycle press/release strobes, with optional hold-to-auto-repeat. It sits between the raw board inputs (KEY inverted to active-high, SW) and game/seed logic. It replaces the per-signal two-flop synchroniser plus separate hold-suppression stage with one block per input group.

---
 rtl/key_conditioner.sv | 170 +++++++++++++++++
 tb/tb_key_conditioner.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/key_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : key_conditioner
// Purpose  : Per-channel synchroniser, counter debouncer, press/release strobes
//            and optional hold-to-auto-repeat (macro KEY_CONDITIONER_REPEAT_EN).
// Revision : 1.0 - initial release
// ============================================================================
module key_conditioner #(
    parameter int CHANNELS        = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 1000,
    parameter int REPEAT_PERIOD   = 250
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] in,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] press,
    output logic [CHANNELS-1:0] release_stb,   // "release" is a reserved word
    output logic [CHANNELS-1:0] fire
);

    if (CHANNELS < 1) begin : g_bad_channels
        $error("key_conditioner: CHANNELS must be >= 1");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("key_conditioner: SYNC_STAGES must be >= 2");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("key_conditioner: DEBOUNCE_CYCLES must be >= 1");
    end
    if (REPEAT_DELAY < 1) begin : g_bad_delay
        $error("key_conditioner: REPEAT_DELAY must be >= 1");
    end
    if (REPEAT_PERIOD < 1) begin : g_bad_period
        $error("key_conditioner: REPEAT_PERIOD must be >= 1");
    end

    localparam int                 c_CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

`ifdef KEY_CONDITIONER_REPEAT_EN
    localparam int c_RC_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int                c_RC_W        = $clog2(c_RC_MAX + 1);
    localparam logic [c_RC_W-1:0] c_DELAY_LAST  = c_RC_W'(REPEAT_DELAY - 1);
    localparam logic [c_RC_W-1:0] c_PERIOD_LAST = c_RC_W'(REPEAT_PERIOD - 1);
    localparam logic [c_RC_W-1:0] c_RC_ONE      = c_RC_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } state_t;
`endif

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] r_sync;
        logic [c_CNT_W-1:0]     r_cnt;
        logic                   r_level;
        logic                   r_press;
        logic                   r_release;
        logic                   w_s;
        logic                   w_accept;
        logic                   w_rise;
        logic                   w_fall;

        assign w_s      = r_sync[SYNC_STAGES-1];
        assign w_accept = (w_s != r_level) && (r_cnt == c_CNT_LAST);
        assign w_rise   = w_accept && w_s;
        assign w_fall   = w_accept && !w_s;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_sync    <= '0;
                r_cnt     <= '0;
                r_level   <= 1'b0;
                r_press   <= 1'b0;
                r_release <= 1'b0;
            end else begin
                r_sync    <= {r_sync[SYNC_STAGES-2:0], in[i]};
                r_press   <= w_rise;
                r_release <= w_fall;
                // Any agreeing sample restarts the count, so short bounce is rejected.
                if (w_s == r_level) begin
                    r_cnt <= '0;
                end else if (w_accept) begin
                    r_level <= w_s;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + c_CNT_ONE;
                end
            end
        end

        assign level[i]       = r_level;
        assign press[i]       = r_press;
        assign release_stb[i] = r_release;

`ifdef KEY_CONDITIONER_REPEAT_EN
        state_t              r_state;
        state_t              w_state_nx;
        logic [c_RC_W-1:0]   r_rc;
        logic [c_RC_W-1:0]   w_rc_nx;
        logic                w_rep;
        logic                r_fire;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_state <= ST_IDLE;
                r_rc    <= '0;
                r_fire  <= 1'b0;
            end else begin
                r_state <= w_state_nx;
                r_rc    <= w_rc_nx;
                r_fire  <= w_rise || w_rep;
            end
        end

        // A release on the same edge as a due repeat wins: no fire, back to idle.
        always_comb begin
            w_state_nx = r_state;
            w_rc_nx    = r_rc;
            w_rep      = 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_rise) begin
                        w_state_nx = ST_DELAY;
                        w_rc_nx    = '0;
                    end
                end
                ST_DELAY: begin
                    if (w_fall) begin
                        w_state_nx = ST_IDLE;
                        w_rc_nx    = '0;
                    end else if (r_rc == c_DELAY_LAST) begin
                        w_rep      = 1'b1;
                        w_state_nx = ST_REPEAT;
                        w_rc_nx    = '0;
                    end else begin
                        w_rc_nx = r_rc + c_RC_ONE;
                    end
                end
                ST_REPEAT: begin
                    if (w_fall) begin
                        w_state_nx = ST_IDLE;
                        w_rc_nx    = '0;
                    end else if (r_rc == c_PERIOD_LAST) begin
                        w_rep   = 1'b1;
                        w_rc_nx = '0;
                    end else begin
                        w_rc_nx = r_rc + c_RC_ONE;
                    end
                end
                default: begin
                    w_state_nx = ST_IDLE;
                    w_rc_nx    = '0;
                end
            endcase
        end

        assign fire[i] = r_fire;
`else
        assign fire[i] = r_press;
`endif
    end

endmodule
`default_nettype wire

// File: tb/tb_key_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_key_conditioner
// Purpose  : Randomised and directed stimulus for key_conditioner, compared
//            every cycle against a sample-window reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_key_conditioner;

    localparam int CH   = 4;
    localparam int SYNC = 2;
    localparam int DEB  = 4;
    localparam int RD   = 10;
    localparam int RP   = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic [CH-1:0] in;
    logic [CH-1:0] level;
    logic [CH-1:0] press;
    logic [CH-1:0] release_stb;
    logic [CH-1:0] fire;

    key_conditioner #(
        .CHANNELS       (CH),
        .SYNC_STAGES    (SYNC),
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in         (in),
        .level      (level),
        .press      (press),
        .release_stb(release_stb),
        .fire       (fire)
    );

    always #5 clk = ~clk;

    // Reference model: a channel flips level when the last DEB synchronised
    // samples (raw input delayed by SYNC edges) all disagree with it.
    logic [CH-1:0] in_q[$];
    logic [CH-1:0] m_level;
    logic [CH-1:0] m_press;
    logic [CH-1:0] m_rel;
    logic [CH-1:0] m_fire;
    int            m_edge;
    int            press_edge[CH];
    logic          all_diff;
    int            age;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            in_q = {};
            for (int k = 0; k < SYNC + DEB; k++) in_q.push_back('0);
            m_level = '0;
            m_press = '0;
            m_rel   = '0;
            m_fire  = '0;
            m_edge  = 0;
            for (int c = 0; c < CH; c++) press_edge[c] = 0;
        end else begin
            m_edge++;
            in_q.push_front(in);
            if (in_q.size() > SYNC + DEB) void'(in_q.pop_back());
            for (int c = 0; c < CH; c++) begin
                all_diff = 1'b1;
                for (int j = 0; j < DEB; j++)
                    if (in_q[SYNC + j][c] == m_level[c]) all_diff = 1'b0;
                m_press[c] = all_diff && !m_level[c];
                m_rel[c]   = all_diff && m_level[c];
                m_fire[c]  = m_press[c];
                if (m_press[c]) press_edge[c] = m_edge;
                if (all_diff) m_level[c] = ~m_level[c];
                age = m_edge - press_edge[c];
`ifdef KEY_CONDITIONER_REPEAT_EN
                if (!all_diff && m_level[c] && age >= RD && ((age - RD) % RP) == 0)
                    m_fire[c] = 1'b1;
`endif
            end
        end
    end

    int n_total = 0;
    int n_pass  = 0;
    int n_press0;
    int n_fire2;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    endtask

    // Apply one input vector for one clock, then compare at the falling edge.
    task automatic cycle(input logic [CH-1:0] v);
        in = v;
        @(negedge clk);
        check("level",   32'(level),       32'(m_level));
        check("press",   32'(press),       32'(m_press));
        check("release", 32'(release_stb), 32'(m_rel));
        check("fire",    32'(fire),        32'(m_fire));
        n_press0 += int'(press[0]);
        n_fire2  += int'(fire[2]);
    endtask

    task automatic run(input logic [CH-1:0] v, input int n);
        repeat (n) cycle(v);
    endtask

    int            hold[CH];
    logic [CH-1:0] cur;

    initial begin
        in       = '0;
        reset    = 1'b1;
        n_press0 = 0;
        n_fire2  = 0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("reset_level",   32'(level),       32'd0);
        check("reset_press",   32'(press),       32'd0);
        check("reset_release", 32'(release_stb), 32'd0);
        check("reset_fire",    32'(fire),        32'd0);
        run('0, 4);

        // Clean press on ch0.
        n_press0 = 0;
        run(4'b0001, 20);
        run(4'b0000, 12);
        check("clean_press_count", 32'(n_press0), 32'd1);

        // Bounce on ch1 every 2 cycles, then settle high.
        for (int k = 0; k < 6; k++) run(k[0] ? 4'b0000 : 4'b0010, 2);
        run(4'b0010, 12);
        run(4'b0000, 12);

        // Auto-repeat on ch2: press at t, repeats t+10, t+13 .. t+28, release at t+30.
        n_fire2 = 0;
        run(4'b0100, 30);
        run(4'b0000, 20);
`ifdef KEY_CONDITIONER_REPEAT_EN
        check("repeat_fire_count", 32'(n_fire2), 32'd8);
`else
        check("repeat_fire_count", 32'(n_fire2), 32'd1);
`endif

        // Early release on ch3: release lands exactly on the first-repeat edge, then earlier.
        run(4'b1000, 10);
        run(4'b0000, 12);
        run(4'b1000, 8);
        run(4'b0000, 12);

        // ch0 and ch2 rise together while ch1 bounces.
        for (int k = 0; k < 20; k++) cycle(4'b0101 | (((k % 4) < 2) ? 4'b0010 : 4'b0000));
        run(4'b0000, 12);

        // Asynchronous reset with ch2 repeating and ch0 mid-debounce.
        run(4'b0100, 18);
        run(4'b0101, 2);
        #2 reset = 1'b1;
        #1;
        check("async_level",   32'(level),       32'd0);
        check("async_press",   32'(press),       32'd0);
        check("async_release", 32'(release_stb), 32'd0);
        check("async_fire",    32'(fire),        32'd0);
        #1 reset = 1'b0;
        n_press0 = 0;
        n_fire2  = 0;
        run(4'b0101, 25);
        check("post_reset_press0", 32'(n_press0), 32'd1);
`ifdef KEY_CONDITIONER_REPEAT_EN
        check("post_reset_fire2", 32'(n_fire2), 32'd5);
`else
        check("post_reset_fire2", 32'(n_fire2), 32'd1);
`endif
        run(4'b0000, 12);

        // Random hold lengths: short runs bounce, long runs press and repeat.
        cur = '0;
        for (int c = 0; c < CH; c++) hold[c] = int'($urandom_range(1, 30));
        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < CH; c++) begin
                if (hold[c] == 0) begin
                    cur[c]  = ~cur[c];
                    hold[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3))
                                                          : int'($urandom_range(4, 40));
                end else begin
                    hold[c] = hold[c] - 1;
                end
            end
            cycle(cur);
        end
        run(4'b0000, 12);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
